// File: rtl/dwc_pkg.sv
// ============================================================================
// Module : dwc_pkg
// Shared encodings, default values and intermediate widths for the
// depthwise requantiser.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dwc_pkg;

  localparam logic [2:0] P_IDX_BIAS0  = 3'd0;
  localparam logic [2:0] P_IDX_SCALE0 = 3'd4;
  localparam logic [2:0] P_IDX_CTRL   = 3'd6;

  localparam int BIAS_W         = 32;
  localparam int SCALE_W        = 16;
  localparam int SHIFT_W        = 5;
  localparam int BIAS_PER_WORD  = 4;
  localparam int SCALE_PER_WORD = 8;
  localparam int WRITABLE_LANES = 16;

  localparam int SUM_A_W = 33;
  localparam int PROD_W  = 49;
  localparam int RND_W   = 50;

  localparam logic signed [BIAS_W-1:0]  DEF_BIAS  = '0;
  localparam logic signed [SCALE_W-1:0] DEF_SCALE = 16'sd1;
  localparam logic [SHIFT_W-1:0]        DEF_SHIFT = '0;
  localparam logic                      DEF_RELU  = 1'b0;

  typedef struct packed {
    logic [SHIFT_W-1:0] shift;
    logic               relu_en;
  } ctrl_t;

  // One extra bit over the product so the rounding add can never wrap.
  function automatic logic signed [RND_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] p,
    input logic [SHIFT_W-1:0]       sh
  );
    logic signed [RND_W-1:0] ext;
    logic signed [RND_W-1:0] rnd;
    ext = RND_W'(p);
    rnd = (sh != '0) ? (RND_W'(1) << (sh - 1'b1)) : '0;
    return (ext + rnd) >>> sh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dwc_rq_fifo.sv
// ============================================================================
// Module : dwc_rq_fifo
// First-word-fall-through output FIFO; push and pop may coincide when full.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dwc_rq_fifo #(
  parameter int WIDTH = 130,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop;

  always_comb begin
    pop      = (count_q != '0) && pop_ready;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // Storage is not reset, so the head is masked while empty.
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

`default_nettype wire

// File: rtl/dwc_requant.sv
// ============================================================================
// Module : dwc_requant
// Per-row hold registers, 3-stage bias/scale/round-clamp lane pipeline and
// credit-controlled output FIFO for depthwise partial sums.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dwc_requant
  import dwc_pkg::*;
#(
  parameter int UNIT_NUM   = 16,
  parameter int ROWS       = 4,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [UNIT_NUM*ROWS*ACC_W-1:0] in_sums,
  input  logic [UNIT_NUM*ROWS-1:0]     in_valids,
  input  logic                         p_valid,
  input  logic [2:0]                   p_idx,
  input  logic [127:0]                 p_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [UNIT_NUM*OUT_W-1:0]    out_data,
  output logic [1:0]                   out_row,
  output logic                         busy,
  output logic                         ovf_err,
  input  logic                         err_clr
);

  localparam int ROW_SUM_W = UNIT_NUM * ACC_W;
  localparam int OUT_DW    = UNIT_NUM * OUT_W;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int CR_W      = CNT_W + 1;

  localparam logic signed [RND_W-1:0] Q_MAX = RND_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RND_W-1:0] Q_MIN = ~Q_MAX;

  logic [ROWS-1:0]           present;
  logic [ROWS-1:0]           hold_v_q, hold_v_d;
  logic [ROWS-1:0]           capture, issue_oh, drop;
  logic [ROWS*ROW_SUM_W-1:0] hold_flat;
  logic [ROW_SUM_W-1:0]      issue_sum;
  logic [1:0]                issue_row;
  logic                      issue;
  logic [CR_W-1:0]           credit_used;

  logic                      s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [1:0]                s1_row_q, s1_row_d, s2_row_q, s2_row_d;
  ctrl_t                     ctrl_q, ctrl_d;
  logic                      ovf_q, ovf_d;

  logic [OUT_DW-1:0]         lane_out;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_valid;
  logic [OUT_DW+1:0]         fifo_dout;
  logic                      unused_valids;

  // Lanes run in lockstep, so lane 0's valid bits stand for every lane.
  assign present       = in_valids[ROWS-1:0];
  assign unused_valids = ^in_valids[UNIT_NUM*ROWS-1:ROWS];

  always_comb begin
    issue_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (hold_v_q[r]) issue_row = 2'(r);
    end
    credit_used = CR_W'(fifo_count) + CR_W'(s1_v_q) + CR_W'(s2_v_q);
    issue       = (|hold_v_q) && (credit_used < CR_W'(FIFO_DEPTH));
    issue_oh    = '0;
    if (issue) issue_oh[issue_row] = 1'b1;
    capture   = present & (~hold_v_q | issue_oh);
    drop      = present & hold_v_q & ~issue_oh;
    hold_v_d  = (hold_v_q & ~issue_oh) | capture;
    issue_sum = hold_flat[issue_row*ROW_SUM_W +: ROW_SUM_W];
  end

  always_comb begin
    s1_v_d   = issue;
    s1_row_d = issue_row;
    s2_v_d   = s1_v_q;
    s2_row_d = s1_row_q;
    ctrl_d   = ctrl_q;
    if (p_valid && (p_idx == P_IDX_CTRL)) begin
      ctrl_d.shift   = p_data[SHIFT_W-1:0];
      ctrl_d.relu_en = p_data[8];
    end
    // A fresh drop wins over a simultaneous clear.
    ovf_d = (ovf_q & ~err_clr) | (|drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v_q <= '0;
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s1_row_q <= '0;
      s2_row_q <= '0;
      ctrl_q   <= '{shift: DEF_SHIFT, relu_en: DEF_RELU};
      ovf_q    <= 1'b0;
    end else begin
      hold_v_q <= hold_v_d;
      s1_v_q   <= s1_v_d;
      s2_v_q   <= s2_v_d;
      s1_row_q <= s1_row_d;
      s2_row_q <= s2_row_d;
      ctrl_q   <= ctrl_d;
      ovf_q    <= ovf_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [ROW_SUM_W-1:0] sum_q, sum_d;

    always_comb begin
      sum_d = sum_q;
      if (capture[r]) begin
        for (int u = 0; u < UNIT_NUM; u++) begin
          sum_d[u*ACC_W +: ACC_W] = in_sums[(u*ROWS+r)*ACC_W +: ACC_W];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum_q <= '0;
      else        sum_q <= sum_d;
    end

    assign hold_flat[r*ROW_SUM_W +: ROW_SUM_W] = sum_q;
  end

  for (genvar u = 0; u < UNIT_NUM; u++) begin : g_lane
    localparam int  BWORD    = u / BIAS_PER_WORD;
    localparam int  BOFS     = (u % BIAS_PER_WORD) * BIAS_W;
    localparam int  SWORD    = u / SCALE_PER_WORD;
    localparam int  SOFS     = (u % SCALE_PER_WORD) * SCALE_W;
    localparam bit  WRITABLE = (u < WRITABLE_LANES);

    logic signed [BIAS_W-1:0]  bias_q, bias_d;
    logic signed [SCALE_W-1:0] scale_q, scale_d;
    logic signed [ACC_W-1:0]   sum;
    logic signed [SUM_A_W-1:0] a_q, a_d;
    logic signed [PROD_W-1:0]  p_q, p_d;
    logic signed [RND_W-1:0]   q;
    logic signed [RND_W-1:0]   lo;
    logic [OUT_W-1:0]          y;

    always_comb begin
      bias_d  = bias_q;
      scale_d = scale_q;
      if (p_valid && WRITABLE && (p_idx == P_IDX_BIAS0 + 3'(BWORD)))
        bias_d = p_data[BOFS +: BIAS_W];
      if (p_valid && WRITABLE && (p_idx == P_IDX_SCALE0 + 3'(SWORD)))
        scale_d = p_data[SOFS +: SCALE_W];

      sum = issue_sum[u*ACC_W +: ACC_W];
      a_d = SUM_A_W'(sum) + SUM_A_W'(bias_q);
      p_d = PROD_W'(a_q) * PROD_W'(scale_q);

      q  = round_shift(p_q, ctrl_q.shift);
      lo = ctrl_q.relu_en ? '0 : Q_MIN;
      if (q > Q_MAX)   y = Q_MAX[OUT_W-1:0];
      else if (q < lo) y = lo[OUT_W-1:0];
      else             y = q[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bias_q  <= DEF_BIAS;
        scale_q <= DEF_SCALE;
        a_q     <= '0;
        p_q     <= '0;
      end else begin
        bias_q  <= bias_d;
        scale_q <= scale_d;
        a_q     <= a_d;
        p_q     <= p_d;
      end
    end

    assign lane_out[u*OUT_W +: OUT_W] = y;
  end

  dwc_rq_fifo #(
    .WIDTH (OUT_DW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s2_v_q),
    .push_data ({s2_row_q, lane_out}),
    .pop_ready (out_ready),
    .out_valid (fifo_valid),
    .out_data  (fifo_dout),
    .count     (fifo_count)
  );

  assign out_valid = fifo_valid;
  assign out_row   = fifo_dout[OUT_DW +: 2];
  assign out_data  = fifo_dout[OUT_DW-1:0];
  assign busy      = (|hold_v_q) | s1_v_q | s2_v_q | fifo_valid;
  assign ovf_err   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_dwc_requant.sv
// ============================================================================
// Module : tb_dwc_requant
// Directed bench for dwc_requant with hand-computed expected rows.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dwc_requant;

  localparam int UNIT_NUM   = 16;
  localparam int ROWS       = 4;
  localparam int ACC_W      = 32;
  localparam int OUT_W      = 8;
  localparam int FIFO_DEPTH = 4;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic [UNIT_NUM*ROWS*ACC_W-1:0] in_sums = '0;
  logic [UNIT_NUM*ROWS-1:0]       in_valids = '0;
  logic                           p_valid = 1'b0;
  logic [2:0]                     p_idx = '0;
  logic [127:0]                   p_data = '0;
  logic                           out_valid;
  logic                           out_ready = 1'b0;
  logic [UNIT_NUM*OUT_W-1:0]      out_data;
  logic [1:0]                     out_row;
  logic                           busy;
  logic                           ovf_err;
  logic                           err_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  dwc_requant #(
    .UNIT_NUM   (UNIT_NUM),
    .ROWS       (ROWS),
    .ACC_W      (ACC_W),
    .OUT_W      (OUT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_sums   (in_sums),
    .in_valids (in_valids),
    .p_valid   (p_valid),
    .p_idx     (p_idx),
    .p_data    (p_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .busy      (busy),
    .ovf_err   (ovf_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_row(input int r, input int v0, input int v1, input int v2, input int vr);
    for (int u = 0; u < UNIT_NUM; u++)
      in_sums[(u*ROWS+r)*ACC_W +: ACC_W] = (u == 0) ? v0 : (u == 1) ? v1 : (u == 2) ? v2 : vr;
  endtask

  function automatic logic [127:0] exp_row(input int e0, input int e1, input int e2, input int er);
    logic [127:0] v;
    for (int u = 0; u < UNIT_NUM; u++)
      v[u*OUT_W +: OUT_W] = 8'((u == 0) ? e0 : (u == 1) ? e1 : (u == 2) ? e2 : er);
    return v;
  endfunction

  task automatic write_param(input logic [2:0] idx, input logic [127:0] d);
    p_valid = 1'b1;
    p_idx   = idx;
    p_data  = d;
    tick();
    p_valid = 1'b0;
    p_data  = '0;
  endtask

  // Upper valid bits belong to other lanes and are filled with noise.
  task automatic pulse(input logic [3:0] rows);
    in_valids      = {$urandom, $urandom};
    in_valids[3:0] = rows;
    tick();
    in_valids = '0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    check(tag, 160'(out_valid), 160'(1));
  endtask

  initial begin
    int seen;

    // Reset state
    #1;
    check("rst_valid", 160'(out_valid), 160'(0));
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_data", 160'(out_data), 160'(0));
    check("rst_row", 160'(out_row), 160'(0));
    check("rst_ovf", 160'(ovf_err), 160'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Identity with clamp, latency and hold-while-stalled
    put_row(0, 100, 300, -300, 7);
    pulse(4'b0001);
    check("lat_e0", 160'(out_valid), 160'(0));
    tick();
    check("lat_e1", 160'(out_valid), 160'(0));
    tick();
    check("lat_e2", 160'(out_valid), 160'(0));
    tick();
    check("lat_e3", 160'(out_valid), 160'(1));
    check("id_data", 160'(out_data), 160'(exp_row(100, 127, -128, 7)));
    check("id_row", 160'(out_row), 160'(0));
    tick();
    check("stall_valid", 160'(out_valid), 160'(1));
    check("stall_data", 160'(out_data), 160'(exp_row(100, 127, -128, 7)));
    out_ready = 1'b1;
    tick();
    check("pop_valid", 160'(out_valid), 160'(0));
    check("pop_busy", 160'(busy), 160'(0));

    // scale=3, shift=2 with round-half-up
    write_param(3'd4, {8{16'sd3}});
    write_param(3'd5, {8{16'sd3}});
    write_param(3'd6, 128'd2);
    put_row(1, 5, -5, -2, 0);
    pulse(4'b0010);
    wait_valid("scale_wait");
    check("scale_row", 160'(out_row), 160'(1));
    check("scale_data", 160'(out_data), 160'(exp_row(4, -4, -1, 0)));
    tick();

    // relu clamp; index 7 must be ignored
    write_param(3'd4, {8{16'sd1}});
    write_param(3'd5, {8{16'sd1}});
    write_param(3'd6, 128'h100);
    write_param(3'd7, '1);
    put_row(2, -50, 20, 200, -1);
    pulse(4'b0100);
    wait_valid("relu_wait");
    check("relu_row", 160'(out_row), 160'(2));
    check("relu_data", 160'(out_data), 160'(exp_row(0, 20, 127, 0)));
    tick();

    // Negative bias on lane 0 only
    write_param(3'd6, 128'd0);
    write_param(3'd0, {96'd0, 32'hFFFF_FFF6});
    put_row(3, 10, 10, -5, 0);
    pulse(4'b1000);
    wait_valid("bias_wait");
    check("bias_row", 160'(out_row), 160'(3));
    check("bias_data", 160'(out_data), 160'(exp_row(0, 10, -5, 0)));
    tick();
    write_param(3'd0, 128'd0);

    // All four rows in one cycle drain on consecutive cycles
    for (int r = 0; r < ROWS; r++) put_row(r, 10 + r, r, r, r);
    pulse(4'b1111);
    wait_valid("burst_wait");
    for (int k = 0; k < ROWS; k++) begin
      check($sformatf("burst_valid%0d", k), 160'(out_valid), 160'(1));
      check($sformatf("burst_row%0d", k), 160'(out_row), 160'(k));
      check($sformatf("burst_data%0d", k), 160'(out_data), 160'(exp_row(10 + k, k, k, k)));
      tick();
    end
    check("burst_ovf", 160'(ovf_err), 160'(0));

    // Back-pressure: fill FIFO and holds, then overflow
    out_ready = 1'b0;
    for (int r = 0; r < ROWS; r++) put_row(r, r + 1, r + 1, r + 1, r + 1);
    pulse(4'b1111);
    repeat (8) tick();
    for (int r = 0; r < ROWS; r++) put_row(r, 21 + r, 21 + r, 21 + r, 21 + r);
    pulse(4'b1111);
    repeat (2) tick();
    check("full_ovf0", 160'(ovf_err), 160'(0));
    check("full_head", 160'(out_data), 160'(exp_row(1, 1, 1, 1)));
    put_row(0, 99, 99, 99, 99);
    pulse(4'b0001);
    check("drop_ovf", 160'(ovf_err), 160'(1));
    err_clr = 1'b1;
    pulse(4'b0001);
    err_clr = 1'b0;
    check("clr_vs_drop", 160'(ovf_err), 160'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_ovf", 160'(ovf_err), 160'(0));
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_valid($sformatf("drain_wait%0d", k));
      check($sformatf("drain_row%0d", k), 160'(out_row), 160'(k % 4));
      check($sformatf("drain_data%0d", k), 160'(out_data),
            160'(exp_row((k < 4) ? k + 1 : 17 + k, (k < 4) ? k + 1 : 17 + k,
                         (k < 4) ? k + 1 : 17 + k, (k < 4) ? k + 1 : 17 + k)));
      tick();
    end
    seen = 0;
    repeat (10) begin
      if (out_valid) seen++;
      tick();
    end
    check("drain_extra", 160'(seen), 160'(0));
    check("drain_busy", 160'(busy), 160'(0));

    // Reset mid-stream with rows in flight
    write_param(3'd6, 128'h101);
    write_param(3'd0, {64'd0, 32'd5, 32'd0});
    put_row(0, 40, 40, 40, 40);
    put_row(1, 41, 41, 41, 41);
    pulse(4'b0011);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 160'(out_valid), 160'(0));
    check("mid_rst_busy", 160'(busy), 160'(0));
    check("mid_rst_data", 160'(out_data), 160'(0));
    check("mid_rst_row", 160'(out_row), 160'(0));
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (out_valid) seen++;
    end
    check("post_rst_quiet", 160'(seen), 160'(0));
    put_row(2, -300, 300, 51, -7);
    pulse(4'b0100);
    wait_valid("post_rst_wait");
    check("post_rst_row", 160'(out_row), 160'(2));
    check("post_rst_defaults", 160'(out_data), 160'(exp_row(-128, 127, 51, -7)));
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
